// File: rtl/regfile_banked.sv
// Banked register file: NRD read ports, pipeline/receive/link writes,
// hardwired-zero entries, optional write bypass, pending-load scoreboard.
//
// Ports:
//   clk, rst             clock (posedge), async active-high reset
//   ready                high once the post-reset clear sequence is done
//   rd_bank/rd_addr      per-port read target (port i at [i*W +: W])
//   rd_data/rd_pend      per-port combinational data and pending flag
//   wa_*                 pipeline writeback port
//   wb_*                 receive-data write port (clears pending bit)
//   link_we/link_data    return-address write to bank 0, LINK_IDX
//   pend_set/pend_*      mark an entry as awaiting receive data
//   drop_err             sticky: a write was dropped
module regfile_banked #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NBANK = 3,
  parameter int NRD   = 3,
  parameter logic [NBANK-1:0] ZERO_EN = 3'b011,
  parameter logic [NBANK*$clog2(NREG)-1:0] ZERO_IDX =
    {5'd0, 5'd31, 5'd0},
  parameter int LINK_IDX = 31,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [NRD*((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] rd_bank,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_pend,
  input  logic                 wa_we,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] wa_bank,
  input  logic [$clog2(NREG)-1:0] wa_addr,
  input  logic [XLEN-1:0]      wa_data,
  input  logic                 wb_we,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] wb_bank,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 link_we,
  input  logic [XLEN-1:0]      link_data,
  input  logic                 pend_set,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] pend_bank,
  input  logic [$clog2(NREG)-1:0] pend_addr,
  output logic                 drop_err
);

  localparam int AW = $clog2(NREG);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_IDX);
  localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);
  localparam logic [BW-1:0] LINK_B = '0;
  localparam bit BYP = (BYPASS != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] mem    [NBANK][NREG];
  logic [NREG-1:0] pend_q [NBANK];
  logic            drop_q;
  logic            run;
  logic            wa_ok, wb_hit, wb_ok;
  logic            link_ok, pend_ok;
  logic            drop_set;

  function automatic logic bank_ok(
    input logic [BW-1:0] b
  );
    return int'(b) < NBANK;
  endfunction

  function automatic logic is_zero(
    input logic [BW-1:0] b,
    input logic [AW-1:0] a
  );
    logic z;
    z = 1'b0;
    for (int k = 0; k < NBANK; k++) begin
      if (ZERO_EN[k] && b == BW'(k) &&
          a == ZERO_IDX[k*AW +: AW])
        z = 1'b1;
    end
    return z;
  endfunction

  assign run      = (state_q == READY);
  assign ready    = run;
  assign drop_err = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR)
        clr_cnt <= clr_cnt + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (clr_cnt == LAST_A) state_d = READY;
      READY: state_d = READY;
    endcase
  end

  // Zero-entry writes still count as hits for
  // the scoreboard clear but never reach storage.
  always_comb begin
    wa_ok   = run && wa_we && bank_ok(wa_bank) &&
              !is_zero(wa_bank, wa_addr);
    wb_hit  = run && wb_we && bank_ok(wb_bank);
    wb_ok   = wb_hit && !is_zero(wb_bank, wb_addr);
    link_ok = run && link_we &&
              !is_zero(LINK_B, LINK_A);
    pend_ok = run && pend_set &&
              bank_ok(pend_bank) &&
              !is_zero(pend_bank, pend_addr);
    if (run)
      drop_set = (wa_we && !bank_ok(wa_bank)) ||
                 (wb_we && !bank_ok(wb_bank));
    else
      drop_set = wa_we || wb_we || link_we;
  end

  // Later assignments win: link > wb > wa.
  always_ff @(posedge clk) begin
    if (!run) begin
      for (int b = 0; b < NBANK; b++)
        mem[b][clr_cnt] <= '0;
    end else begin
      if (wa_ok)
        mem[wa_bank][wa_addr] <= wa_data;
      if (wb_ok)
        mem[wb_bank][wb_addr] <= wb_data;
      if (link_ok)
        mem[LINK_B][LINK_A] <= link_data;
    end
  end

  // Set after clear so a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++)
        pend_q[b] <= '0;
    end else if (run) begin
      if (wb_hit)
        pend_q[wb_bank][wb_addr] <= 1'b0;
      if (pend_ok)
        pend_q[pend_bank][pend_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_q <= 1'b0;
    else if (drop_set)
      drop_q <= 1'b1;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [BW-1:0]   b;
    logic [AW-1:0]   a;
    logic            valid;
    logic [XLEN-1:0] d;
    logic            p;

    assign b     = rd_bank[i*BW +: BW];
    assign a     = rd_addr[i*AW +: AW];
    assign valid = run && bank_ok(b) && !is_zero(b, a);

    always_comb begin
      d = '0;
      if (valid) begin
        if (BYP && link_ok && b == LINK_B &&
            a == LINK_A)
          d = link_data;
        else if (BYP && wb_ok && b == wb_bank &&
                 a == wb_addr)
          d = wb_data;
        else if (BYP && wa_ok && b == wa_bank &&
                 a == wa_addr)
          d = wa_data;
        else
          d = mem[b][a];
      end
    end

    assign p = valid && pend_q[b][a] &&
               !(BYP && wb_hit && b == wb_bank &&
                 a == wb_addr);

    assign rd_data[i*XLEN +: XLEN] = d;
    assign rd_pend[i] = p;
  end

endmodule
